// File: rtl/refclk_ce_gen.sv
// refclk_ce_gen: NUM_CH phase-aligned clock-enable pulses and divided square waves from refclk,
// with lock tracking and a valid/ready port that reconfigures one channel and realigns them all.
module refclk_ce_gen #(
  parameter int NUM_CH        = 2,
  parameter int CNT_W         = 8,
  parameter int LOCK_CYCLES   = 16,
  parameter int DEF_DIV       = 2,
  parameter int DEF_PHASE     = 0,
  parameter int GATE_UNLOCKED = 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce_o,
  output logic [NUM_CH-1:0] clk_o,
  output logic              locked
);

  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_DIV   = CNT_W'((DEF_DIV == 0) ? 1 : DEF_DIV);
  localparam logic [CNT_W-1:0] RST_PHASE = CNT_W'(DEF_PHASE);

  typedef enum logic [1:0] {
    ALIGN    = 2'd0,
    UNLOCKED = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [LCW-1:0]                lockCnt_q, lockCnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  div_q, div_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  phase_q, phase_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0]             ce_q, ce_d;
  logic [NUM_CH-1:0]             clk_q, clk_d;
  logic                          err_q, err_d;

  logic             accept;
  logic             chOk;
  logic             runEn;
  logic [CNT_W-1:0] wrDiv;
  logic [CNT_W-1:0] wrPhase;

  function automatic logic [CNT_W-1:0] clampPhase(input logic [CNT_W-1:0] div,
                                                  input logic [CNT_W-1:0] ph);
    return (ph >= div) ? (div - ONE) : ph;
  endfunction

  // Counter start value that places the ce pulse 'phase' cycles after UNLOCKED begins.
  function automatic logic [CNT_W-1:0] alignLoad(input logic [CNT_W-1:0] div,
                                                 input logic [CNT_W-1:0] ph);
    logic [CNT_W-1:0] p;
    p = clampPhase(div, ph);
    return (p == '0) ? '0 : (div - p);
  endfunction

  function automatic logic [CNT_W-1:0] nextCount(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W-1:0] div);
    return (cnt >= (div - ONE)) ? '0 : (cnt + ONE);
  endfunction

  function automatic logic [CNT_W:0] halfUp(input logic [CNT_W-1:0] div);
    return ({1'b0, div} + (CNT_W+1)'(1)) >> 1;
  endfunction

  assign cfg_ready = (state_q != ALIGN);
  assign locked    = (state_q == LOCKED);
  assign cfg_err   = err_q;
  assign ce_o      = ce_q;
  assign clk_o     = clk_q;

  assign accept  = cfg_valid && cfg_ready;
  assign chOk    = ({1'b0, cfg_ch} < 5'(NUM_CH));
  assign wrDiv   = (cfg_div == '0) ? ONE : cfg_div;
  assign wrPhase = clampPhase(wrDiv, cfg_phase);

  always_comb begin
    state_d   = state_q;
    lockCnt_d = lockCnt_q;
    div_d     = div_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;

    case (state_q)
      ALIGN: begin
        for (int c = 0; c < NUM_CH; c++) begin
          phase_d[c] = clampPhase(div_q[c], phase_q[c]);
          cnt_d[c]   = alignLoad(div_q[c], phase_q[c]);
        end
        lockCnt_d = '0;
        state_d   = UNLOCKED;
      end
      UNLOCKED: begin
        for (int c = 0; c < NUM_CH; c++) begin
          cnt_d[c] = nextCount(cnt_q[c], div_q[c]);
        end
        lockCnt_d = lockCnt_q + LCW'(1);
        if (lockCnt_q == LOCK_LAST) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        for (int c = 0; c < NUM_CH; c++) begin
          cnt_d[c] = nextCount(cnt_q[c], div_q[c]);
        end
      end
      default: begin
        state_d = ALIGN;
      end
    endcase

    // A valid write realigns every channel; an out-of-range channel only flags an error.
    if (accept) begin
      if (chOk) begin
        state_d = ALIGN;
        for (int c = 0; c < NUM_CH; c++) begin
          if (cfg_ch == 4'(c)) begin
            div_d[c]   = wrDiv;
            phase_d[c] = wrPhase;
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Outputs are decoded from the next counter value so the registers line up with cnt_q.
  always_comb begin
    runEn = (state_d == LOCKED) || ((GATE_UNLOCKED == 0) && (state_d == UNLOCKED));
    ce_d  = '0;
    clk_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ce_d[c]  = runEn && (cnt_d[c] == '0);
      clk_d[c] = runEn && ({1'b0, cnt_d[c]} < halfUp(div_d[c]));
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ALIGN;
      lockCnt_q <= '0;
      div_q     <= {NUM_CH{RST_DIV}};
      phase_q   <= {NUM_CH{RST_PHASE}};
      cnt_q     <= '0;
      ce_q      <= '0;
      clk_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lockCnt_q <= lockCnt_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      ce_q      <= ce_d;
      clk_q     <= clk_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_refclk_ce_gen.sv
// Bench for refclk_ce_gen: scenario tasks compared against a time-since-alignment model.
module tb_refclk_ce_gen;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int LOCK   = 16;
  localparam int DDIV   = 2;
  localparam int DPH    = 0;

  logic              refclk;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [3:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_phase;
  logic              cfg_err;
  logic [NUM_CH-1:0] ce_o;
  logic [NUM_CH-1:0] clk_o;
  logic              locked;

  int checks = 0;
  int errors = 0;

  // Model: stored (clamped) settings plus the number of cycles since the last ALIGN cycle.
  int mDiv [NUM_CH];
  int mPh  [NUM_CH];
  int mSince;
  bit mErr;
  bit lastAcc;

  refclk_ce_gen #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LOCK_CYCLES(LOCK),
    .DEF_DIV(DDIV), .DEF_PHASE(DPH), .GATE_UNLOCKED(1)
  ) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
    .ce_o(ce_o), .clk_o(clk_o), .locked(locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  function automatic bit expLocked();
    return mSince >= LOCK + 1;
  endfunction

  function automatic bit expReady();
    return mSince > 0;
  endfunction

  function automatic int runPos(int c);
    int d, p, k;
    d = mDiv[c];
    p = (mPh[c] >= d) ? d - 1 : mPh[c];
    k = mSince - 1;
    return (((k - p) % d) + d) % d;
  endfunction

  function automatic logic [NUM_CH-1:0] expCe();
    logic [NUM_CH-1:0] e;
    e = '0;
    for (int c = 0; c < NUM_CH; c++) e[c] = expLocked() && (runPos(c) == 0);
    return e;
  endfunction

  function automatic logic [NUM_CH-1:0] expClk();
    logic [NUM_CH-1:0] e;
    e = '0;
    for (int c = 0; c < NUM_CH; c++) e[c] = expLocked() && (runPos(c) < (mDiv[c] + 1) / 2);
    return e;
  endfunction

  task automatic modelReset();
    for (int c = 0; c < NUM_CH; c++) begin
      mDiv[c] = (DDIV == 0) ? 1 : DDIV;
      mPh[c]  = DPH;
    end
    mSince = 0;
    mErr   = 1'b0;
  endtask

  // Advance the model with the inputs present at the coming edge, then step past that edge.
  task automatic tick();
    int d, p;
    lastAcc = 1'b0;
    if (rst) begin
      modelReset();
    end else begin
      mErr = 1'b0;
      if (cfg_valid && expReady()) begin
        lastAcc = 1'b1;
        if (int'(cfg_ch) < NUM_CH) begin
          d = (cfg_div == 0) ? 1 : int'(cfg_div);
          p = (int'(cfg_phase) >= d) ? d - 1 : int'(cfg_phase);
          mDiv[cfg_ch] = d;
          mPh[cfg_ch]  = p;
          mSince = 0;
        end else begin
          mErr = 1'b1;
          mSince++;
        end
      end else begin
        mSince++;
      end
    end
    @(posedge refclk);
    #1;
  endtask

  task automatic applyWrite(input int ch, input int dv, input int ph);
    cfg_ch    = 4'(ch);
    cfg_div   = CNT_W'(dv);
    cfg_phase = CNT_W'(ph);
    cfg_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
    tick();
    tick();
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=0", cfg_ready); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b exp=0", cfg_err); end
    checks++; if (ce_o !== '0) begin errors++; $display("[TB] FAIL reset_ce got=%b exp=0", ce_o); end
    checks++; if (clk_o !== '0) begin errors++; $display("[TB] FAIL reset_clk got=%b exp=0", clk_o); end
    rst = 1'b0;
  endtask

  task automatic test_lock_timing();
    for (int n = 0; n < 24; n++) begin
      checks++; if (locked !== (n >= LOCK + 1)) begin errors++; $display("[TB] FAIL lock_cycle%0d got=%b exp=%b", n, locked, (n >= LOCK + 1)); end
      checks++; if (ce_o !== expCe()) begin errors++; $display("[TB] FAIL lock_ce cycle%0d got=%b exp=%b", n, ce_o, expCe()); end
      checks++; if (clk_o !== expClk()) begin errors++; $display("[TB] FAIL lock_clk cycle%0d got=%b exp=%b", n, clk_o, expClk()); end
      if (n >= LOCK + 1) begin
        checks++; if (ce_o !== (((n - 1) % 2 == 0) ? 2'b11 : 2'b00)) begin errors++; $display("[TB] FAIL lock_ce_alt cycle%0d got=%b", n, ce_o); end
      end
      tick();
    end
  endtask

  task automatic test_reconfig();
    int firstLock;
    firstLock = -1;
    applyWrite(1, 4, 2);
    tick();
    cfg_valid = 1'b0;
    checks++; if (lastAcc !== 1'b1) begin errors++; $display("[TB] FAIL reconfig_accept got=%b exp=1", lastAcc); end
    for (int n = 0; n < 28; n++) begin
      if (locked === 1'b1 && firstLock < 0) firstLock = n;
      checks++; if (cfg_ready !== (n != 0)) begin errors++; $display("[TB] FAIL reconfig_ready n%0d got=%b exp=%b", n, cfg_ready, (n != 0)); end
      checks++; if (ce_o !== expCe()) begin errors++; $display("[TB] FAIL reconfig_ce n%0d got=%b exp=%b", n, ce_o, expCe()); end
      checks++; if (clk_o !== expClk()) begin errors++; $display("[TB] FAIL reconfig_clk n%0d got=%b exp=%b", n, clk_o, expClk()); end
      if (n >= LOCK + 1) begin
        checks++; if (clk_o[1] !== (((n - 1) % 4) >= 2)) begin errors++; $display("[TB] FAIL reconfig_clk1_pattern n%0d got=%b", n, clk_o[1]); end
      end
      tick();
    end
    checks++; if (firstLock !== LOCK + 1) begin errors++; $display("[TB] FAIL reconfig_relock got=%0d exp=%0d", firstLock, LOCK + 1); end
  endtask

  task automatic test_clamp();
    applyWrite(0, 0, 5);
    tick();
    cfg_valid = 1'b0;
    for (int n = 0; n < 22; n++) begin
      checks++; if (ce_o !== expCe()) begin errors++; $display("[TB] FAIL clamp1_ce n%0d got=%b exp=%b", n, ce_o, expCe()); end
      checks++; if (clk_o !== expClk()) begin errors++; $display("[TB] FAIL clamp1_clk n%0d got=%b exp=%b", n, clk_o, expClk()); end
      if (n >= LOCK + 1) begin
        checks++; if ({ce_o[0], clk_o[0]} !== 2'b11) begin errors++; $display("[TB] FAIL clamp1_const n%0d got=%b exp=11", n, {ce_o[0], clk_o[0]}); end
      end
      tick();
    end
    applyWrite(0, 3, 7);
    tick();
    cfg_valid = 1'b0;
    for (int n = 0; n < 24; n++) begin
      checks++; if (ce_o !== expCe()) begin errors++; $display("[TB] FAIL clamp2_ce n%0d got=%b exp=%b", n, ce_o, expCe()); end
      checks++; if (clk_o !== expClk()) begin errors++; $display("[TB] FAIL clamp2_clk n%0d got=%b exp=%b", n, clk_o, expClk()); end
      if (n >= LOCK + 1) begin
        checks++; if (clk_o[0] !== (((n - 1 - 2 + 3) % 3) < 2)) begin errors++; $display("[TB] FAIL clamp2_duty n%0d got=%b", n, clk_o[0]); end
      end
      tick();
    end
  endtask

  task automatic test_bad_channel();
    applyWrite(9, 5, 1);
    tick();
    cfg_valid = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL badch_err got=%b exp=1", cfg_err); end
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL badch_locked got=%b exp=1", locked); end
    checks++; if (ce_o !== expCe()) begin errors++; $display("[TB] FAIL badch_ce got=%b exp=%b", ce_o, expCe()); end
    tick();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL badch_err_pulse got=%b exp=0", cfg_err); end
    for (int n = 0; n < 6; n++) begin
      checks++; if (clk_o !== expClk()) begin errors++; $display("[TB] FAIL badch_clk n%0d got=%b exp=%b", n, clk_o, expClk()); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int firstLock;
    firstLock = -1;
    applyWrite(1, 6, 3);
    tick();
    cfg_valid = 1'b0;
    for (int n = 0; n < 11; n++) tick();
    rst = 1'b1;
    applyWrite(0, 7, 2);
    tick();
    rst = 1'b0;
    cfg_valid = 1'b0;
    for (int n = 0; n < 24; n++) begin
      if (locked === 1'b1 && firstLock < 0) firstLock = n;
      checks++; if (ce_o !== expCe()) begin errors++; $display("[TB] FAIL rstmid_ce n%0d got=%b exp=%b", n, ce_o, expCe()); end
      checks++; if (clk_o !== expClk()) begin errors++; $display("[TB] FAIL rstmid_clk n%0d got=%b exp=%b", n, clk_o, expClk()); end
      tick();
    end
    checks++; if (firstLock !== LOCK + 1) begin errors++; $display("[TB] FAIL rstmid_relock got=%0d exp=%0d", firstLock, LOCK + 1); end
  endtask

  task automatic test_hold_valid();
    rst = 1'b1;
    applyWrite(0, 5, 1);
    tick();
    rst = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_ready0 got=%b exp=0", cfg_ready); end
    tick();
    checks++; if (lastAcc !== 1'b0) begin errors++; $display("[TB] FAIL hold_model_noaccept got=%b exp=0", lastAcc); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_ready1 got=%b exp=1", cfg_ready); end
    tick();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_align got=%b exp=0", cfg_ready); end
    for (int n = 0; n < 22; n++) begin
      checks++; if (locked !== (n >= LOCK + 1)) begin errors++; $display("[TB] FAIL hold_locked n%0d got=%b exp=%b", n, locked, (n >= LOCK + 1)); end
      checks++; if (ce_o !== expCe()) begin errors++; $display("[TB] FAIL hold_ce n%0d got=%b exp=%b", n, ce_o, expCe()); end
      checks++; if (clk_o !== expClk()) begin errors++; $display("[TB] FAIL hold_clk n%0d got=%b exp=%b", n, clk_o, expClk()); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    applyWrite(0, 3, 1);
    tick();
    applyWrite(1, 5, 4);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_align_ready got=%b exp=0", cfg_ready); end
    tick();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_unlocked_ready got=%b exp=1", cfg_ready); end
    tick();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_second_align got=%b exp=0", cfg_ready); end
    for (int n = 0; n < 22; n++) begin
      checks++; if (locked !== (n >= LOCK + 1)) begin errors++; $display("[TB] FAIL b2b_locked n%0d got=%b exp=%b", n, locked, (n >= LOCK + 1)); end
      checks++; if (ce_o !== expCe()) begin errors++; $display("[TB] FAIL b2b_ce n%0d got=%b exp=%b", n, ce_o, expCe()); end
      checks++; if (clk_o !== expClk()) begin errors++; $display("[TB] FAIL b2b_clk n%0d got=%b exp=%b", n, clk_o, expClk()); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if (!cfg_valid && ($urandom_range(0, 19) == 0)) begin
        applyWrite(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), int'($urandom_range(0, 15)));
      end
      rst = ($urandom_range(0, 149) == 0);
      checks++; if (locked !== expLocked()) begin errors++; $display("[TB] FAIL rand_locked n%0d got=%b exp=%b", n, locked, expLocked()); end
      checks++; if (cfg_ready !== expReady()) begin errors++; $display("[TB] FAIL rand_ready n%0d got=%b exp=%b", n, cfg_ready, expReady()); end
      checks++; if (cfg_err !== mErr) begin errors++; $display("[TB] FAIL rand_err n%0d got=%b exp=%b", n, cfg_err, mErr); end
      checks++; if (ce_o !== expCe()) begin errors++; $display("[TB] FAIL rand_ce n%0d got=%b exp=%b", n, ce_o, expCe()); end
      checks++; if (clk_o !== expClk()) begin errors++; $display("[TB] FAIL rand_clk n%0d got=%b exp=%b", n, clk_o, expClk()); end
      tick();
      if (lastAcc) cfg_valid = 1'b0;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
    lastAcc = 1'b0;
    modelReset();
    test_reset();
    test_lock_timing();
    test_reconfig();
    test_clamp();
    test_bad_channel();
    test_reset_mid();
    test_hold_valid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
